ksa_pipe_adder: RTL and testbench

//  Parametrised, pipelined Kogge-Stone add/subtract unit with valid/ready flow control and a sideband tag.
//  It generalises the fixed 32-bit combinational KSA to any WIDTH, with selectable pipeline cut points.
//  It adds a subtract mode and a signed-overflow flag.
//  It serves as the final carry-propagate adder behind the multiplier's reduction tree and as a standalone ALU adder.

---
 rtl/ksa_pipe_adder.sv | 80 ++++++++
 tb/tb_ksa_pipe_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone add/subtract with valid/ready flow control and a sideband tag.
module ksa_pipe_adder #(
  parameter int         WIDTH    = 32,
  parameter int         TAG_W    = 4,
  parameter logic [7:0] REG_MASK = 8'b00000100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
);
  localparam int L = $clog2(WIDTH);
  // Stage word: {valid, tag, cin, original p, group p, group g}
  localparam int SW = 2 + TAG_W + 3 * WIDTH;
  localparam logic [63:0] RM = 64'(REG_MASK);
  logic en;
  logic [SW-1:0] st_c [L+1];
  logic [SW-1:0] st_r [L+1];
  logic [WIDTH-1:0] b_eff, p0, g0;
  logic cin;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;
  assign b_eff   = i_sub ? ~i_b : i_b;
  assign cin     = i_c0 ^ i_sub;
  assign p0      = i_a ^ b_eff;
  // Carry-in folded into bit 0 so L levels cover all WIDTH positions.
  assign g0      = (i_a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & cin};
  assign st_c[0] = {i_valid, i_tag, cin, p0, p0, g0};
  genvar k;
  generate
    for (k = 0; k <= L; k++) begin : g_stage
      if (k > 0) begin : g_lvl
        localparam int D = 1 << (k - 1);
        logic [WIDTH-1:0] gp_i, pp_i, gp_o, pp_o;
        assign gp_i = st_r[k-1][WIDTH-1:0];
        assign pp_i = st_r[k-1][2*WIDTH-1:WIDTH];
        always_comb begin
          gp_o = gp_i;
          pp_o = pp_i;
          for (int j = D; j < WIDTH; j++) begin
            gp_o[j] = gp_i[j] | (pp_i[j] & gp_i[j-D]);
            pp_o[j] = pp_i[j] & pp_i[j-D];
          end
        end
        assign st_c[k] = {st_r[k-1][SW-1:2*WIDTH], pp_o, gp_o};
      end
      if (RM[k]) begin : g_rank
        logic [SW-1:0] rank_q;
        always_ff @(posedge i_clk or negedge i_rst_n)
          if (!i_rst_n) rank_q <= '0;
          else if (en) rank_q <= st_c[k];
        assign st_r[k] = rank_q;
      end else begin : g_thru
        assign st_r[k] = st_c[k];
      end
    end
  endgenerate
  logic [SW-1:0] f;
  logic [WIDTH-1:0] gf, s_d;
  logic [WIDTH+TAG_W+2:0] out_d, out_q;
  assign f     = st_r[L];
  assign gf    = f[WIDTH-1:0];
  assign s_d   = f[3*WIDTH-1:2*WIDTH] ^ {gf[WIDTH-2:0], f[3*WIDTH]};
  assign out_d = {f[SW-1], f[SW-2:3*WIDTH+1], gf[WIDTH-1], gf[WIDTH-1] ^ gf[WIDTH-2], s_d};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) out_q <= '0;
    else if (en) out_q <= out_d;
  assign {o_valid, o_tag, o_carry, o_ovf, o_s} = out_q;
endmodule

// File: tb/tb_ksa_pipe_adder.sv
// tb_ksa_pipe_adder: directed checks on the default 32-bit unit plus randomised checks on 8-bit/LAT1 and 37-bit/LAT8 builds.
module tb_ksa_pipe_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b1, c0 = 1'b0, sub = 1'b0;
  logic [3:0] tag = '0;
  logic [63:0] a = '0, b = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  logic m_ro, m_vo, m_c, m_ovf;
  logic [31:0] m_s;
  logic [3:0] m_tag;
  ksa_pipe_adder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(m_ro),
    .i_a(a[31:0]), .i_b(b[31:0]), .i_c0(c0), .i_sub(sub), .i_tag(tag),
    .o_valid(m_vo), .i_ready(i_ready), .o_s(m_s), .o_carry(m_c), .o_ovf(m_ovf), .o_tag(m_tag)
  );

  logic r8_ro, r8_vo, r8_c, r8_ovf;
  logic [7:0] r8_s;
  logic [3:0] r8_tag;
  ksa_pipe_adder #(.WIDTH(8), .TAG_W(4), .REG_MASK(8'h00)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(r8_ro),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_c0(c0), .i_sub(sub), .i_tag(tag),
    .o_valid(r8_vo), .i_ready(i_ready), .o_s(r8_s), .o_carry(r8_c), .o_ovf(r8_ovf), .o_tag(r8_tag)
  );

  logic r37_ro, r37_vo, r37_c, r37_ovf;
  logic [36:0] r37_s;
  logic [3:0] r37_tag;
  ksa_pipe_adder #(.WIDTH(37), .TAG_W(4), .REG_MASK(8'hFF)) dut37 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(r37_ro),
    .i_a(a[36:0]), .i_b(b[36:0]), .i_c0(c0), .i_sub(sub), .i_tag(tag),
    .o_valid(r37_vo), .i_ready(i_ready), .o_s(r37_s), .o_carry(r37_c), .o_ovf(r37_ovf), .o_tag(r37_tag)
  );

  typedef struct packed {
    logic [31:0] a, b;
    logic c0, sub;
    logic [31:0] s;
    logic c, v;
  } vec_t;

  // Behavioural reference: full-precision add of masked operands; returns {tag, ovf, carry, s}.
  function automatic logic [69:0] model(input int w, input logic [63:0] x, y,
                                        input logic ci, sb, input logic [3:0] t);
    logic [64:0] mask, full;
    logic [63:0] xa, yb, ss;
    logic cc, ov;
    mask = (65'd1 << w) - 65'd1;
    xa = x & mask[63:0];
    yb = (sb ? ~y : y) & mask[63:0];
    full = {1'b0, xa} + {1'b0, yb} + 65'(ci ^ sb);
    ss = full[63:0] & mask[63:0];
    cc = full[w];
    ov = (xa[w-1] == yb[w-1]) && (ss[w-1] != xa[w-1]);
    return {t, ov, cc, ss};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    i_valid = 1'b0;
    #3;
    total++;
    if ({m_vo, m_c, m_ovf, m_tag, m_s} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {m_vo, m_c, m_ovf, m_tag, m_s});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({m_ro, m_vo} !== 2'b10) begin
      bad++;
      $display("FAIL reset_ready: got ready=%b valid=%b want ready=1 valid=0", m_ro, m_vo);
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    a = 64'hFFFFFFFF; b = 64'h1; c0 = 1'b0; sub = 1'b0; tag = 4'd3; i_valid = 1'b1;
    @(negedge clk) i_valid = 1'b0;
    total++;
    if (m_vo !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: got valid=%b want 0", m_vo);
    end
    @(negedge clk);
    total++;
    if ({m_vo, m_c, m_ovf, m_tag, m_s} !== {1'b1, 1'b1, 1'b0, 4'd3, 32'h0}) begin
      bad++;
      $display("FAIL latency_add: got v=%b c=%b o=%b t=%h s=%h want v=1 c=1 o=0 t=3 s=0",
               m_vo, m_c, m_ovf, m_tag, m_s);
    end
  endtask

  task automatic test_arith;
    vec_t vt [10];
    vt[0] = {32'h5,        32'h7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[1] = {32'h5,        32'h5,        1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[2] = {32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[3] = {32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[4] = {32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vt[5] = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vt[6] = {32'h0,        32'h0,        1'b1, 1'b0, 32'h1,        1'b0, 1'b0};
    vt[7] = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[8] = {32'h0,        32'hFFFFFFFF, 1'b0, 1'b1, 32'h1,        1'b0, 1'b0};
    vt[9] = {32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = {32'h0, vt[i].a}; b = {32'h0, vt[i].b}; c0 = vt[i].c0; sub = vt[i].sub;
      tag = 4'(i); i_valid = 1'b1;
      @(negedge clk) i_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({m_vo, m_c, m_ovf, m_tag, m_s} !== {1'b1, vt[i].c, vt[i].v, 4'(i), vt[i].s}) begin
        bad++;
        $display("FAIL arith_%0d: got v=%b c=%b o=%b t=%h s=%h want v=1 c=%b o=%b t=%h s=%h",
                 i, m_vo, m_c, m_ovf, m_tag, m_s, vt[i].c, vt[i].v, 4'(i), vt[i].s);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, stalls = 0;
    logic prev_stall = 1'b0;
    logic [38:0] prev = '0, now;
    logic [31:0] exp_s;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      i_ready = !(m_vo && m_tag == 4'd1 && stalls < 3);
      if (!i_ready) stalls++;
      i_valid = sent < 4;
      a = {32'h0, 32'h11111111 * 32'(sent)}; b = 64'h0F0F0F0F;
      c0 = 1'b0; sub = 1'b0; tag = 4'(sent);
      #1;
      now = {m_vo, m_tag, m_c, m_ovf, m_s};
      if (prev_stall) begin
        total++;
        if (now !== prev) begin
          bad++;
          $display("FAIL stall_stable: got %h want %h", now, prev);
        end
      end
      if (!i_ready) begin
        total++;
        if (m_ro !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready: got %b want 0", m_ro);
        end
      end
      if (m_vo && i_ready) begin
        exp_s = 32'h11111111 * 32'(got) + 32'h0F0F0F0F;
        total++;
        if ({m_tag, m_s} !== {4'(got), exp_s}) begin
          bad++;
          $display("FAIL b2b_order: got t=%h s=%h want t=%h s=%h", m_tag, m_s, 4'(got), exp_s);
        end
        got++;
      end
      if (i_valid && m_ro) sent++;
      prev_stall = m_vo && !i_ready;
      prev = now;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    total++;
    if (got != 4 || sent != 4 || stalls != 3) begin
      bad++;
      $display("FAIL b2b_count: got emitted=%0d sent=%0d stalls=%0d want 4 4 3", got, sent, stalls);
    end
  endtask

  task automatic test_reset_flight;
    @(negedge clk);
    a = 64'hFFFFFFFF; b = 64'h1; c0 = 1'b0; sub = 1'b0; tag = 4'd5; i_valid = 1'b1;
    @(negedge clk) tag = 4'd6;
    @(posedge clk);
    #2;
    total++;
    if (m_vo !== 1'b1) begin
      bad++;
      $display("FAIL flight_pre: got valid=%b want 1", m_vo);
    end
    rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    total++;
    if ({m_vo, m_c, m_ovf, m_tag, m_s} !== '0) begin
      bad++;
      $display("FAIL flight_async: got %h want 0", {m_vo, m_c, m_ovf, m_tag, m_s});
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({m_vo, m_ro} !== 2'b01) begin
        bad++;
        $display("FAIL flight_stale_%0d: got valid=%b ready=%b want 0 1", i, m_vo, m_ro);
      end
    end
  endtask

  task automatic test_random;
    logic [69:0] q8 [$], q37 [$];
    logic [69:0] e;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      @(negedge clk);
      i_valid = (cyc < 3000) && ($urandom_range(0, 3) != 0);
      i_ready = (cyc >= 3000) || ($urandom_range(0, 3) != 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = '1;
      c0 = 1'($urandom);
      sub = 1'($urandom);
      tag = 4'($urandom);
      #1;
      if (r8_vo && i_ready) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL rand8_extra: got unexpected tag=%h want none", r8_tag);
        end else begin
          e = q8.pop_front();
          if ({r8_tag, r8_ovf, r8_c, r8_s} !== {e[69:64], e[7:0]}) begin
            bad++;
            $display("FAIL rand8: got %h want %h", {r8_tag, r8_ovf, r8_c, r8_s}, {e[69:64], e[7:0]});
          end
        end
      end
      if (r37_vo && i_ready) begin
        total++;
        if (q37.size() == 0) begin
          bad++;
          $display("FAIL rand37_extra: got unexpected tag=%h want none", r37_tag);
        end else begin
          e = q37.pop_front();
          if ({r37_tag, r37_ovf, r37_c, r37_s} !== {e[69:64], e[36:0]}) begin
            bad++;
            $display("FAIL rand37: got %h want %h", {r37_tag, r37_ovf, r37_c, r37_s}, {e[69:64], e[36:0]});
          end
        end
      end
      if (i_valid && r8_ro) q8.push_back(model(8, a, b, c0, sub, tag));
      if (i_valid && r37_ro) q37.push_back(model(37, a, b, c0, sub, tag));
    end
    total++;
    if (q8.size() != 0 || q37.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: got pending8=%0d pending37=%0d want 0 0", q8.size(), q37.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
